fp32_div_multicycle: RTL and testbench
======================================

// Module: fp32_div_multicycle
// PURPOSE
//  Iterative IEEE-754 single-precision divider, quotient = input_a / input_b: the inverse of the
//  team's single-cycle FP32 multiplier. Uses the same simplified format (implicit 1, no denormal/NaN).
//  Shift-subtract mantissa core, one quotient bit per cycle; valid/ready on both sides. Intended as the
//  sequential DUT in the idpv-test equivalence/verification suite.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MAN_W   23   stored mantissa width; quotient core produces QB = MAN_W+2 = 25 bits
//  BIAS    127  exponent bias
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  in_valid      in   1   operands valid
//  in_ready      out  1   divider idle, can accept
//  input_a       in   32  dividend {sign, exp, man}
//  input_b       in   32  divisor
//  out_valid     out  1   result valid; held until out_ready
//  out_ready     in   1   consumer accepts result
//  quotient      out  32  result, registered
//  overflow      out  1   result exponent >= 255, saturated to signed infinity
//  underflow     out  1   result exponent <= 0, flushed to signed zero
//  div_by_zero   out  1   input_b == 0 (exp and man fields zero, any sign)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, all flags=0, counter=0.
//  FSM: IDLE -(in_valid)-> CALC (normal) | DONE (special); CALC -(25 iters)-> NORM -> DONE;
//   DONE -(out_ready)-> IDLE. in_ready=1 only in IDLE; input_a/b captured on accept edge only.
//  Special cases decided at accept, priority order:
//   1 divisor zero: quotient={sa^sb,8'hFF,23'h0}, div_by_zero=1 (also for 0/0).
//   2 dividend zero: quotient=32'h0 (+0 regardless of signs), flags 0.
//   Special -> out_valid on the first edge after accept.
//  Normal: ma={1,man_a}, mb={1,man_b} (24b). Remainder r=ma; 25 iterations: r>=mb ? (q bit 1, r-=mb)
//   : q bit 0; then r<<=1. q MSB first, q in [2^23, 2^25).
//  NORM: exp computed in signed EXP_W+2 bits: e = ea - eb + BIAS - (q[24] ? 0 : 1);
//   man = q[24] ? q[23:1] : q[22:0]; truncation, no rounding, remainder discarded.
//   e>=255 -> overflow=1, quotient={s,8'hFF,23'h0}; e<=0 -> underflow=1, quotient={s,31'h0};
//   else quotient={s,e[7:0],man}. s = sa^sb.
//  Latency normal: out_valid rises on the 27th rising edge after the accept edge (25 CALC + NORM + 1).
//  Flags are mutually exclusive, valid only with out_valid, cleared on leaving DONE.
//  Back-pressure: in DONE with out_ready=0, quotient/flags/out_valid stable indefinitely.
//  Handshake in DONE & out_ready: IDLE next cycle; no same-cycle re-accept (throughput 1 per 28+ cycles).
//  rst asserted mid-CALC/DONE: immediate return to reset values; partial result discarded, no out_valid.
//  in_valid dropping while busy: ignored.
// STRUCTURE
//  Shared package fp_pkg: EXP_W/MAN_W/BIAS constants, state enum {IDLE,CALC,NORM,DONE},
//   FP_POS_INF/FP_ZERO constants, fp32 field-unpack typedef.
//  Sub-module fp_mant_divider: 24-bit restoring shift-subtract core (start, busy, done, q[24:0]),
//   owns iteration counter. Top owns FSM, special cases, exponent arithmetic, output registers.
// TESTING
//  6.0/2.0: 0x40C00000 / 0x40000000 -> 0x40400000, flags 0, out_valid 27 cycles after accept.
//  1/3 truncation: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (not ...AB); -1/3 -> 0xBEAAAAAA.
//  Specials: 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1, out_valid 1 cycle after accept;
//   0x00000000 / 0x40000000 -> 0x00000000, flags 0.
//  Range: 0x7F000000 / 0x3E800000 -> 0x7F800000 overflow=1; 0x00800000 / 0x40000000 -> 0x00000000
//   underflow=1.
//  Back-pressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored;
//   release -> IDLE next cycle, next operand pair accepted.
//  Reset mid-CALC (cycle 12): all outputs at reset values next cycle, then a fresh 6.0/2.0 gives 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the iterative divider.
// Holds the field widths and bias, the quotient width of the mantissa core,
// the controller state encoding, saturation constants and a field-unpack view
// of a packed single-precision word.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;
   localparam int QB    = MAN_W + 2;   // quotient bits produced by the core
   localparam int EW    = EXP_W + 2;   // signed exponent working width
   localparam int CNT_W = $clog2(QB);

   localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);
   localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);

   localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   // Zero means both exponent and mantissa fields clear; sign is ignored.
   function automatic logic is_zero(input fp32_t x);
      return (x.exp == '0) && (x.man == '0);
   endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring shift-subtract mantissa divider, one quotient bit per clock.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start      load operands and begin (ignored while busy is not checked;
//              the controller only pulses it from idle)
//   ma, mb     24-bit mantissas with the hidden one already attached
//   busy       iterations in progress
//   done       one-cycle pulse the clock after the final iteration
//   q          QB-bit quotient, MSB first, valid while done is high
module fp_mant_divider
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [MAN_W:0]   ma,
   input  logic [MAN_W:0]   mb,
   output logic             busy,
   output logic             done,
   output logic [QB-1:0]    q
);

   // Remainder needs one bit above the divisor: after a shift it is < 2*mb.
   logic [QB-1:0]    rem;
   logic [CNT_W-1:0] cnt;
   logic [QB-1:0]    mb_ext;
   logic             ge;
   logic [QB-1:0]    diff;

   always_comb begin
      mb_ext = {1'b0, mb};
      ge     = (rem >= mb_ext);
      diff   = rem - mb_ext;
   end

   // cnt is a down-counter; terminal count zero marks the last quotient bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem  <= '0;
         q    <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem  <= {1'b0, ma};
            q    <= '0;
            cnt  <= CNT_W'(QB - 1);
            busy <= 1'b1;
         end else if (busy) begin
            if (ge) begin
               rem <= diff << 1;
               q   <= {q[QB-2:0], 1'b1};
            end else begin
               rem <= rem << 1;
               q   <= {q[QB-2:0], 1'b0};
            end
            if (cnt == '0) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fp32_div_multicycle.sv
// Iterative FP32 divider: quotient = input_a / input_b, simplified format
// (implicit one, no denormals/NaN), truncating.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   in_valid / in_ready     operand handshake; ready only while idle
//   input_a, input_b        dividend and divisor {sign, exp, man}
//   out_valid / out_ready   result handshake; result held until taken
//   quotient                registered result
//   overflow, underflow     saturated to signed infinity / flushed to signed zero
//   div_by_zero             divisor was zero (any sign)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | mantissa core iterating, one quotient bit per clock
// NORM  | exponent adjust, range check, load result registers
// DONE  | result presented (specials load it on the first DONE clock)
module fp32_div_multicycle
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] input_a,
   input  logic [31:0] input_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic        overflow,
   output logic        underflow,
   output logic        div_by_zero
);

   state_t            state;
   fp32_t             a_in;
   fp32_t             b_in;
   logic              s_reg;
   logic [EXP_W-1:0]  ea_reg;
   logic [EXP_W-1:0]  eb_reg;
   logic              dbz_pend;
   logic              special_in;
   logic              core_start;
   logic              core_busy;
   logic              core_done;
   logic [QB-1:0]     q_core;
   logic signed [EW-1:0] e_calc;
   logic [MAN_W-1:0]  man_n;
   logic              e_ovf;
   logic              e_unf;

   always_comb begin
      a_in       = input_a;
      b_in       = input_b;
      special_in = is_zero(b_in) || is_zero(a_in);
      core_start = (state == IDLE) && in_valid && !special_in;
   end

   fp_mant_divider u_mant_div (
      .clk   (clk),
      .rst   (rst),
      .start (core_start),
      .ma    ({1'b1, a_in.man}),
      .mb    ({1'b1, b_in.man}),
      .busy  (core_busy),
      .done  (core_done),
      .q     (q_core)
   );

   // A quotient below 2^24 means the mantissa ratio was < 1: drop one from
   // the exponent and take the bits one position lower.
   always_comb begin
      e_calc = $signed({2'b00, ea_reg}) - $signed({2'b00, eb_reg}) + BIAS_S
               - $signed({{(EW-1){1'b0}}, ~q_core[QB-1]});
      man_n  = q_core[QB-1] ? q_core[QB-2:1] : q_core[QB-3:0];
      e_ovf  = (e_calc >= EXP_MAX);
      e_unf  = e_calc[EW-1] || (e_calc == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= FP_ZERO;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         div_by_zero <= 1'b0;
         s_reg       <= 1'b0;
         ea_reg      <= '0;
         eb_reg      <= '0;
         dbz_pend    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s_reg    <= a_in.sign ^ b_in.sign;
                  ea_reg   <= a_in.exp;
                  eb_reg   <= b_in.exp;
                  dbz_pend <= is_zero(b_in);
                  in_ready <= 1'b0;
                  state    <= special_in ? DONE : CALC;
               end
            end
            CALC: begin
               if (core_done && !core_busy) begin
                  state <= NORM;
               end
            end
            NORM: begin
               state     <= DONE;
               out_valid <= 1'b1;
               if (e_ovf) begin
                  overflow <= 1'b1;
                  quotient <= FP_POS_INF | {s_reg, 31'h0};
               end else if (e_unf) begin
                  underflow <= 1'b1;
                  quotient  <= {s_reg, 31'h0};
               end else begin
                  quotient <= {s_reg, e_calc[EXP_W-1:0], man_n};
               end
            end
            DONE: begin
               if (!out_valid) begin
                  // Only the special-case path arrives here without a result.
                  out_valid <= 1'b1;
                  if (dbz_pend) begin
                     div_by_zero <= 1'b1;
                     quotient    <= FP_POS_INF | {s_reg, 31'h0};
                  end else begin
                     quotient <= FP_ZERO;
                  end
               end else if (out_ready) begin
                  state       <= IDLE;
                  in_ready    <= 1'b1;
                  out_valid   <= 1'b0;
                  overflow    <= 1'b0;
                  underflow   <= 1'b0;
                  div_by_zero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_div_multicycle.sv
module tb_fp32_div_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic        overflow;
   logic        underflow;
   logic        div_by_zero;

   always #5 clk = ~clk;

   fp32_div_multicycle dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .input_a     (input_a),
      .input_b     (input_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .overflow    (overflow),
      .underflow   (underflow),
      .div_by_zero (div_by_zero)
   );

   typedef struct packed {
      logic [31:0] q;
      logic        ovf;
      logic        unf;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: quotient bits = floor(ma * 2^24 / mb), then normalise.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        r;
      logic [63:0] ma;
      logic [63:0] mb;
      logic [63:0] qv;
      int          e;
      logic        s;
      r = '0;
      s = a[31] ^ b[31];
      if (b[30:0] == 31'h0) begin
         r.q   = {s, 8'hFF, 23'h0};
         r.dbz = 1'b1;
         return r;
      end
      if (a[30:0] == 31'h0) return r;
      ma = {40'h0, 1'b1, a[22:0]};
      mb = {40'h0, 1'b1, b[22:0]};
      qv = (ma << 24) / mb;
      e  = int'(a[30:23]) - int'(b[30:23]) + 127 - (qv[24] ? 0 : 1);
      if (e >= 255) begin
         r.q   = {s, 8'hFF, 23'h0};
         r.ovf = 1'b1;
      end else if (e <= 0) begin
         r.q   = {s, 31'h0};
         r.unf = 1'b1;
      end else begin
         r.q = {s, e[7:0], (qv[24] ? qv[23:1] : qv[22:0])};
      end
      return r;
   endfunction

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_in_ready"},  32'(in_ready), 32'd1);
      check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_val({tag, "_quotient"},  quotient, 32'h0);
      check_val({tag, "_flags"},     32'({overflow, underflow, div_by_zero}), 32'd0);
   endtask

   task automatic drive_accept(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      input_a  = a;
      input_b  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic compare_out();
      exp_t e;
      check_val("sb_size", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_val("quotient",    quotient, e.q);
         check_val("overflow",    32'(overflow), 32'(e.ovf));
         check_val("underflow",   32'(underflow), 32'(e.unf));
         check_val("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
   endtask

   task automatic take_result();
      compare_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("out_valid_clr", 32'(out_valid), 32'd0);
      check_val("in_ready_back", 32'(in_ready), 32'd1);
      check_val("flags_clr", 32'({overflow, underflow, div_by_zero}), 32'd0);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b);
      int lat;
      int exp_lat;
      exp_lat = (b[30:0] == 31'h0 || a[30:0] == 31'h0) ? 1 : 27;
      sb.push_back(model(a, b));
      drive_accept(a, b);
      check_val("in_ready_busy", 32'(in_ready), 32'd0);
      wait_out(lat);
      check_val("latency", 32'(lat), 32'(exp_lat));
      if (out_valid) take_result();
      else sb.delete();
   endtask

   initial begin
      int   lat;
      int   seen;
      exp_t e;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      input_a   = 32'h0;
      input_b   = 32'h0;
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(32'h40C0_0000, 32'h4000_0000);   // 6/2
      run_op(32'h3F80_0000, 32'h4040_0000);   // 1/3
      run_op(32'hBF80_0000, 32'h4040_0000);   // -1/3
      run_op(32'hBF80_0000, 32'h0000_0000);   // -1/0
      run_op(32'h0000_0000, 32'h4000_0000);   // 0/2
      run_op(32'h8000_0000, 32'h8000_0000);   // -0/-0
      run_op(32'h7F00_0000, 32'h3E80_0000);   // overflow
      run_op(32'h0080_0000, 32'h4000_0000);   // underflow
      run_op(32'hC0E0_0000, 32'h3FC0_0000);   // -7/1.5

      for (int i = 0; i < 8; i++) begin
         run_op({1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)},
                {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)});
      end

      // Back-pressure: result must hold while the consumer stalls.
      sb.push_back(model(32'h4110_0000, 32'h4040_0000));   // 9/3
      drive_accept(32'h4110_0000, 32'h4040_0000);
      wait_out(lat);
      check_val("bp_latency", 32'(lat), 32'd27);
      if (out_valid && sb.size() > 0) begin
         e        = sb[0];
         in_valid = 1'b1;
         input_a  = 32'h3F80_0000;
         input_b  = 32'h4000_0000;
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("bp_quotient",  quotient, e.q);
            check_val("bp_out_valid", 32'(out_valid), 32'd1);
            check_val("bp_in_ready",  32'(in_ready), 32'd0);
         end
         in_valid = 1'b0;
         take_result();
      end else begin
         sb.delete();
      end
      run_op(32'h4120_0000, 32'h4080_0000);   // 10/4, accepted right after release

      // Reset during CALC discards the operation.
      drive_accept(32'h40C0_0000, 32'h4000_0000);
      repeat (11) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_val("midrst_no_out", 32'(seen), 32'd0);
      run_op(32'h40C0_0000, 32'h4000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
